// File: rtl/bias_add_stage.sv
// -----------------------------------------------------------------------------
// bias_add_stage
//
// Adds the per-output-channel bias to each signed accumulator beat, rounds
// (half up), arithmetic-shifts and saturates the result to OUT_WIDTH bits.
// The bias is fetched from an external single-port RAM with RAM_LATENCY cycles
// of read latency; accumulator beats wait in a valid-tagged delay line so they
// meet their bias. Results are queued in a small FIFO of RAM_LATENCY+2 entries.
// Upstream is only granted a beat when FIFO occupancy plus beats still in the
// delay line leaves room, so nothing is ever dropped under backpressure.
//
// Optional feature macro: BIAS_ADD_RELU_EN -- when defined, negative results
// are clamped to zero after saturation.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   s_valid/s_ready/s_data/s_first   accumulator stream in (s_first = channel 0)
//   bias_rd_addr/bias_rd_en          bias RAM read request (combinational)
//   bias_rd_data                     bias RAM read data, RAM_LATENCY after request
//   m_valid/m_ready/m_data           result stream out
//   m_ch/m_last                      channel of m_data, last-channel flag
// -----------------------------------------------------------------------------
module bias_add_stage #(
  parameter int NUM_CHANNELS = 64,
  parameter int ACC_WIDTH    = 32,
  parameter int BIAS_WIDTH   = 16,
  parameter int OUT_WIDTH    = 16,
  parameter int OUT_SHIFT    = 8,
  parameter int RAM_LATENCY  = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [ACC_WIDTH-1:0]            s_data,
  input  logic                            s_first,
  output logic [$clog2(NUM_CHANNELS)-1:0] bias_rd_addr,
  output logic                            bias_rd_en,
  input  logic [BIAS_WIDTH-1:0]           bias_rd_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [OUT_WIDTH-1:0]            m_data,
  output logic [$clog2(NUM_CHANNELS)-1:0] m_ch,
  output logic                            m_last
);

  localparam int CW    = $clog2(NUM_CHANNELS);
  localparam int DEPTH = RAM_LATENCY + 2;
  localparam int PW    = $clog2(DEPTH);
  localparam int CNTW  = $clog2(DEPTH + 1);
  // Two guard bits: one for the bias add, one for the rounding constant.
  localparam int SUMW  = ACC_WIDTH + 2;

  localparam logic [CW-1:0]          LAST_CH  = CW'(NUM_CHANNELS - 1);
  localparam logic [PW-1:0]          LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CNTW:0]          CREDITS  = (CNTW + 1)'(DEPTH);
  // Half an LSB of the shifted result; zero when no shift is applied.
  localparam logic signed [SUMW-1:0] ROUND_C  = SUMW'((64'd1 << OUT_SHIFT) >> 1);
  localparam logic signed [SUMW-1:0] OUT_MAX  = SUMW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [SUMW-1:0] OUT_MIN  = SUMW'(-(64'sd1 <<< (OUT_WIDTH - 1)));

  // Circular pointer increment for a FIFO whose depth need not be a power of 2.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == LAST_PTR) begin
      n = {PW{1'b0}};
    end else begin
      n = p + PW'(1);
    end
    return n;
  endfunction

  // Clamp the shifted sum into the signed output range (optionally ReLU).
  function automatic logic [OUT_WIDTH-1:0] saturate(input logic signed [SUMW-1:0] v);
    logic [OUT_WIDTH-1:0] r;
    if (v > OUT_MAX) begin
      r = OUT_MAX[OUT_WIDTH-1:0];
    end else if (v < OUT_MIN) begin
      r = OUT_MIN[OUT_WIDTH-1:0];
    end else begin
      r = v[OUT_WIDTH-1:0];
    end
`ifdef BIAS_ADD_RELU_EN
    if (r[OUT_WIDTH-1]) begin
      r = {OUT_WIDTH{1'b0}};
    end else begin
      r = r;
    end
`endif
    return r;
  endfunction

  logic [CW-1:0]                          r_ch_cnt;
  logic [CW-1:0]                          w_ch;
  logic                                   w_accept;
  logic [RAM_LATENCY-1:0]                 r_dl_vld;
  logic [RAM_LATENCY-1:0][ACC_WIDTH-1:0]  r_dl_data;
  logic [RAM_LATENCY-1:0][CW-1:0]         r_dl_ch;
  logic [CNTW-1:0]                        w_in_flight;
  logic                                   w_tail_vld;
  logic [ACC_WIDTH-1:0]                   w_tail_data;
  logic [CW-1:0]                          w_tail_ch;
  logic signed [SUMW-1:0]                 w_sum;
  logic signed [SUMW-1:0]                 w_shifted;
  logic [OUT_WIDTH-1:0]                   w_result;
  logic [OUT_WIDTH-1:0]                   r_fifo_data [DEPTH];
  logic [CW-1:0]                          r_fifo_ch   [DEPTH];
  logic                                   r_fifo_last [DEPTH];
  logic [PW-1:0]                          r_wr_ptr;
  logic [PW-1:0]                          r_rd_ptr;
  logic [CNTW-1:0]                        r_count;
  logic                                   w_push;
  logic                                   w_pop;

  // Count beats still travelling through the delay line.
  always_comb begin
    w_in_flight = {CNTW{1'b0}};
    for (int i = 0; i < RAM_LATENCY; i++) begin
      w_in_flight = w_in_flight + CNTW'(r_dl_vld[i]);
    end
  end

  // Accept side: credit check, channel selection and bias read request.
  always_comb begin
    s_ready      = ({1'b0, r_count} + {1'b0, w_in_flight}) < CREDITS;
    // rst_n gating keeps the RAM idle while the stage is held in reset.
    w_accept     = s_valid && s_ready && rst_n;
    w_ch         = s_first ? {CW{1'b0}} : r_ch_cnt;
    bias_rd_en   = w_accept;
    bias_rd_addr = w_ch;
  end

  // Bias add, round half up, arithmetic shift and saturate on the aligned beat.
  always_comb begin
    w_tail_vld  = r_dl_vld[RAM_LATENCY-1];
    w_tail_data = r_dl_data[RAM_LATENCY-1];
    w_tail_ch   = r_dl_ch[RAM_LATENCY-1];
    w_sum       = SUMW'($signed(w_tail_data)) + SUMW'($signed(bias_rd_data));
    w_shifted   = (w_sum + ROUND_C) >>> OUT_SHIFT;
    w_result    = saturate(w_shifted);
  end

  // FIFO handshake and head-of-queue outputs.
  always_comb begin
    m_valid = (r_count != {CNTW{1'b0}});
    w_pop   = m_valid && m_ready;
    // Credit accounting guarantees room whenever the delay line delivers.
    w_push  = w_tail_vld;
    m_data  = r_fifo_data[r_rd_ptr];
    m_ch    = r_fifo_ch[r_rd_ptr];
    m_last  = r_fifo_last[r_rd_ptr];
  end

  // Channel counter: follows each accepted beat, wraps at the last channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch_cnt <= {CW{1'b0}};
    end else if (w_accept) begin
      r_ch_cnt <= (w_ch == LAST_CH) ? {CW{1'b0}} : w_ch + CW'(1);
    end
  end

  // Delay line carrying accumulator and channel alongside the bias RAM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dl_vld  <= {RAM_LATENCY{1'b0}};
      r_dl_data <= {(RAM_LATENCY * ACC_WIDTH){1'b0}};
      r_dl_ch   <= {(RAM_LATENCY * CW){1'b0}};
    end else begin
      r_dl_vld[0]  <= w_accept;
      r_dl_data[0] <= s_data;
      r_dl_ch[0]   <= w_ch;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        r_dl_vld[i]  <= r_dl_vld[i-1];
        r_dl_data[i] <= r_dl_data[i-1];
        r_dl_ch[i]   <= r_dl_ch[i-1];
      end
    end
  end

  // Output FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CNTW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_data[i] <= {OUT_WIDTH{1'b0}};
        r_fifo_ch[i]   <= {CW{1'b0}};
        r_fifo_last[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= w_result;
        r_fifo_ch[r_wr_ptr]   <= w_tail_ch;
        r_fifo_last[r_wr_ptr] <= (w_tail_ch == LAST_CH);
        r_wr_ptr              <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: doc/bias_add_stage.md
# bias_add_stage

Consumes the signed convolution accumulator stream, fetches the per-output-channel bias from the single-port bias block RAM, then adds, rounds, shifts and saturates each beat into the output activation width. Sits directly downstream of the MAC accumulator and drives the read port (rd_addr/rd_en, rd_data) of the bias RAM; its output feeds the activation writeback. Accepts one beat per cycle under valid/ready backpressure.

## Interface
- NUM_CHANNELS, 64: output channels; bias RAM depth.
- ACC_WIDTH, 32: signed accumulator width.
- BIAS_WIDTH, 16: signed bias width; matches bias RAM DATA_WIDTH.
- OUT_WIDTH, 16: signed output width.
- OUT_SHIFT, 8: arithmetic right shift after the add (0..ACC_WIDTH-1).
- RAM_LATENCY, 1: bias RAM read latency; 1 = no output register, 2 = output register "true".

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- s_valid  in  1  accumulator beat valid.
- s_ready  out  1  stage can accept a beat.
- s_data  in  ACC_WIDTH  signed accumulator.
- s_first  in  1  beat is channel 0; restarts channel count.
- bias_rd_addr  out  $clog2(NUM_CHANNELS)  bias RAM read address.
- bias_rd_en  out  1  bias RAM read enable.
- bias_rd_data  in  BIAS_WIDTH  bias RAM read data.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts.
- m_data  out  OUT_WIDTH  signed result.
- m_ch  out  $clog2(NUM_CHANNELS)  channel index of m_data.
- m_last  out  1  m_ch == NUM_CHANNELS-1.

## Operation
- Accept: beat taken when s_valid && s_ready. Channel = 0 if s_first, else internal ch_cnt. ch_cnt then becomes channel+1, wrapping NUM_CHANNELS-1 -> 0.
- Fetch: bias_rd_en = s_valid && s_ready (combinational); bias_rd_addr = accepted channel. No read issued otherwise; the RAM's hold-on-idle behaviour is not relied upon.
- Alignment: s_data and channel travel in a RAM_LATENCY-deep valid-tagged delay line, meeting bias_rd_data RAM_LATENCY cycles after accept.
- Arithmetic: sum = s_data + sign_ext(bias), ACC_WIDTH+1 bits, no overflow. If OUT_SHIFT>0 add 2^(OUT_SHIFT-1) (round half up), then arithmetic shift right by OUT_SHIFT. Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Output FIFO: depth RAM_LATENCY+2, holds {m_data, m_ch, m_last}; head drives outputs; pop on m_valid && m_ready.
- Credit rule: s_ready = (fifo_count + in_flight) < RAM_LATENCY+2, where in_flight = valid beats in the delay line. FIFO never overflows; no beat is dropped.
- Simultaneous push and pop on a full FIFO: both occur, count unchanged.
- Reset (any time, incl. mid-stream): ch_cnt=0, delay line and FIFO cleared (entries zeroed), in-flight beats discarded. Outputs during reset: s_ready=1, bias_rd_en=0 (s_valid ignored), bias_rd_addr=0, m_valid=0, m_data=0, m_ch=0, m_last=0.

## Timing
- Beat accepted at cycle T: bias read issued in T, bias_rd_data sampled in T+RAM_LATENCY, result written to FIFO at end of T+RAM_LATENCY, m_valid at T+RAM_LATENCY+1. Latency RAM_LATENCY+1.
- Throughput 1 beat/cycle with m_ready held high.
- m_ready low: at most RAM_LATENCY+2 beats accepted beyond the last pop, then s_ready falls (combinational from registered counts, not from m_ready).
- m_valid/m_data stable until popped.

## Configuration
- BIAS_ADD_RELU_EN defined: after saturation, negative results forced to 0 (m_data in [0, 2^(OUT_WIDTH-1)-1]).
- Not defined: signed saturated result passed unchanged.

## Test plan
- Ramp: NUM_CHANNELS=4, biases {10,-20,300,-5}, OUT_SHIFT=0, s_data=100 on 8 beats, s_first on beat 0, m_ready=1 -> m_data 110,80,400,95 repeating; m_last on beats 3 and 7; first m_valid 2 cycles after first accept (RAM_LATENCY=1), 3 (RAM_LATENCY=2).
- Rounding: OUT_SHIFT=8, bias 0, s_data 383 -> 1; 384 -> 2; -385 -> -2; -384 -> -1.
- Saturation: OUT_WIDTH=16, OUT_SHIFT=0, s_data 40000, bias 100 -> 32767; s_data -40000 -> -32768 (0 with BIAS_ADD_RELU_EN).
- Backpressure: continuous s_valid, m_ready low 10 cycles -> exactly RAM_LATENCY+2 beats accepted, s_ready=0 thereafter; m_ready high -> all beats emerge in order, none lost or duplicated.
- s_first mid-frame: s_first on the 3rd beat -> that beat uses bias address 0, next uses 1; bias_rd_addr checked each accept.
- Reset mid-stream: rst_n low with 3 beats in flight -> m_valid=0 next edge, all listed reset values; after release first beat uses channel 0.
